imem_fetch_arbiter: RTL

Shares the single byte-wide instruction memory port between the CPU fetch path and the program loader. Fetches are sequenced as four byte reads assembled big-endian into one 32-bit instruction; loader writes are single bytes at an auto-incrementing pointer. Sits between the fetch stage, the program-load interface and a byte-addressable synchronous-read instruction RAM.

---
 rtl/imem_fetch_arbiter.sv | 133 +++++++++++++
 1 files changed

// File: rtl/imem_fetch_arbiter.sv
// imem_fetch_arbiter
// Shares one byte-wide, synchronous-read instruction RAM port between the CPU
// fetch path and the program loader.
//   - A fetch reads four consecutive bytes (a, a+1, a+2, a+3, wrapping) and
//     assembles them big-endian into one 32-bit instruction.
//   - A load writes one byte per grant at an auto-incrementing pointer.
// Ports:
//   clock, reset                    clock, asynchronous active-high reset
//   fetch_req/fetch_addr            fetch request and byte address
//   fetch_accept                    combinational grant of a fetch
//   fetch_busy                      fetch sequence in progress
//   fetch_valid/fetch_instruction   one-cycle completion pulse + result
//   load_start                      return the load pointer to 0
//   load_valid/load_byte            loader byte offer
//   load_ready                      combinational grant (byte written now)
//   mem_addr/mem_we/mem_wdata       RAM address, write enable, write data
//   mem_rdata                       RAM read data, one cycle after mem_addr
module imem_fetch_arbiter #(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  fetch_req,
  input  logic [31:0]           fetch_addr,
  output logic                  fetch_accept,
  output logic                  fetch_busy,
  output logic                  fetch_valid,
  output logic [31:0]           fetch_instruction,
  input  logic                  load_start,
  input  logic                  load_valid,
  input  logic [7:0]            load_byte,
  output logic                  load_ready,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_we,
  output logic [7:0]            mem_wdata,
  input  logic [7:0]            mem_rdata
);

  typedef enum logic [1:0] {IDLE, RD, LAST} state_t;
  typedef enum logic {GRANT_FETCH, GRANT_LOAD} grant_t;

  state_t                state_reg, state_next;
  grant_t                last_grant_reg;
  logic [1:0]            cnt_reg;
  logic [ADDR_WIDTH-1:0] base_reg;
  logic [ADDR_WIDTH-1:0] load_ptr_reg;
  logic [7:0]            lane_reg [3];
  logic                  valid_reg;
  logic [31:0]           instr_reg;

  // Only the low address bits select a byte in this RAM.
  logic unused_addr_bits;
  assign unused_addr_bits = ^fetch_addr[31:ADDR_WIDTH];

  assign fetch_busy        = (state_reg != IDLE);
  assign fetch_valid       = valid_reg;
  assign fetch_instruction = instr_reg;
  assign mem_wdata         = load_byte;

  always_comb begin
    state_next   = state_reg;
    fetch_accept = 1'b0;
    load_ready   = 1'b0;
    mem_we       = 1'b0;
    mem_addr     = load_ptr_reg;
    case (state_reg)
      IDLE: begin
        // On a tie the requester that was not served last wins.
        if (fetch_req && (!load_valid || last_grant_reg == GRANT_LOAD)) begin
          fetch_accept = 1'b1;
          state_next   = RD;
        end else if (load_valid) begin
          load_ready = 1'b1;
          mem_we     = 1'b1;
        end
      end
      RD: begin
        mem_addr = base_reg + {{(ADDR_WIDTH-2){1'b0}}, cnt_reg};
        if (cnt_reg == 2'd3) state_next = LAST;
      end
      LAST: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg      <= IDLE;
      cnt_reg        <= 2'd0;
      base_reg       <= '0;
      load_ptr_reg   <= '0;
      last_grant_reg <= GRANT_LOAD;
      valid_reg      <= 1'b0;
      instr_reg      <= 32'd0;
    end else begin
      state_reg <= state_next;
      valid_reg <= (state_reg == LAST);

      if (fetch_accept) begin
        base_reg       <= fetch_addr[ADDR_WIDTH-1:0];
        cnt_reg        <= 2'd0;
        last_grant_reg <= GRANT_FETCH;
      end else if (state_reg == RD) begin
        cnt_reg <= cnt_reg + 2'd1;
      end

      if (load_ready) last_grant_reg <= GRANT_LOAD;

      // A write granted alongside load_start already used the old pointer.
      if (load_start)      load_ptr_reg <= '0;
      else if (load_ready) load_ptr_reg <= load_ptr_reg + 1'b1;

      if (state_reg == LAST)
        instr_reg <= {lane_reg[0], lane_reg[1], lane_reg[2], mem_rdata};
    end
  end

  // Byte lanes for [31:24], [23:16], [15:8]. Read data lags the issued
  // address by one cycle, so lane gi fills on the edge where cnt == gi+1.
  for (genvar gi = 0; gi < 3; gi++) begin : g_lane
    always_ff @(posedge clock or posedge reset) begin
      if (reset)
        lane_reg[gi] <= 8'd0;
      else if (state_reg == RD && cnt_reg == 2'(gi + 1))
        lane_reg[gi] <= mem_rdata;
    end
  end

endmodule
